mem_access_block: RTL and testbench
===================================

// Module: mem_access_block
// PURPOSE
//  RV64I memory stage: consumer of execute-stage outputs (pc/inst/rdata/raddr + valids).
//  Issues loads/stores to data memory over a req/gnt/rvalid handshake.
//  Aligns and extends load data, and passes ALU results straight through to writeback.
//  Stalls execute while a memory transaction is outstanding.
// PARAMETERS
//  TimeoutCycles  255  max cycles in REQ+WAIT before bus error (8-bit counter, 1..255)
// PORTS
//  clk            in   1   clock, rising edge
//  reset          in   1   asynchronous, active-low reset
//  pc_i/_valid    in   64/1  instruction PC from execute
//  inst_i/_valid  in   32/1  instruction word from execute
//  rdata_i/_valid in   64/1  ALU result (non-mem) or store data (stores)
//  raddr_i/_valid in   64/1  effective byte address (loads/stores)
//  stall_o        out  1   high while state!=IDLE; upstream holds inputs
//  dmem_req_o     out  1   request; held until dmem_gnt_i
//  dmem_we_o      out  1   1=store, 0=load
//  dmem_addr_o    out  64  {raddr[63:3],3'b0}
//  dmem_be_o      out  8   byte enables
//  dmem_wdata_o   out  64  lane-shifted store data
//  dmem_gnt_i     in   1   request accepted this cycle
//  dmem_rvalid_i  in   1   load data valid
//  dmem_rdata_i   in   64  load data, full doubleword
//  pc_o/_valid    out  64/1  to writeback
//  inst_o/_valid  out  32/1
//  wdata_o/_valid out  64/1  writeback value; valid=0 for stores/errors
//  misalign_o     out  1   pulse with pc_o_valid: misaligned access, no request made
//  bus_err_o      out  1   pulse with pc_o_valid: timeout
// BEHAVIOUR
//  - Reset (async, low): state=IDLE; all outputs and valids 0; counter 0.
//    Mid-transaction reset drops dmem_req_o immediately; the transaction is abandoned.
//  - Accept: in IDLE when all four input valids are 1.
//  - Non-mem op: outputs registered next cycle (latency 1); wdata_o=rdata_i.
//    wdata_o_valid=0 for BRANCH/STORE opcodes.
//  - Misalign: H needs addr[0]=0, W needs addr[1:0]=0, D needs addr[2:0]=0.
//    On violation: no request; next cycle pc_o_valid=inst_o_valid=misalign_o=1, wdata_o_valid=0.
//  - FSM states:
//    IDLE -> REQ on an aligned load/store.
//    REQ: dmem_req_o=1.
//      On gnt, load -> WAIT.
//      On gnt, store -> IDLE; outputs valid next cycle, wdata_o_valid=0.
//    WAIT: on dmem_rvalid_i -> IDLE; wdata_o_valid=1 next cycle.
//    rvalid is ignored outside WAIT. gnt is ignored outside REQ.
//  - Timing: accept at cycle N -> req at N+1. Min load latency 3 (gnt N+1, rvalid N+2, out N+3).
//    Min store latency 2.
//  - Timeout: counter counts in REQ/WAIT and clears on IDLE.
//    At TimeoutCycles -> IDLE, req dropped, bus_err_o=1 with valids next cycle, wdata_o_valid=0.
//    If rvalid arrives in the same cycle as the timeout, rvalid wins.
//  - Load extract (funct3): lane=addr[2:0].
//    LB 000 / LH 001 / LW 010 sign-extend; LD 011 full 64 bits;
//    LBU 100 / LHU 101 / LWU 110 zero-extend. funct3=111 is treated as non-mem.
//  - Store (funct3 SB/SH/SW/SD): be=(8'h01/03/0F/FF)<<lane; wdata=data<<(8*lane).
//  - Output valids are 1-cycle pulses. pc_o/inst_o/wdata_o hold their last value otherwise.
// STRUCTURE
//  - rv64.vh: OP_LOAD 7'b0000011, OP_STORE 7'b0100011, OP_BRANCH, FUNCT3_LB..LWU, FUNCT3_SB..SD,
//    and the MEM_IDLE/MEM_REQ/MEM_WAIT state encodings.
//  - Sub-module mem_align (combinational): funct3+lane+data -> be, wdata, load result, misalign.
//  - Output registers built with the flop module.
// TESTING
//  - ADD result 64'h1234 passed through -> wdata_o=64'h1234, valid 1 cycle after accept, stall_o never 1.
//  - LB addr 0x1003, mem 64'h0000_0000_8000_0000 -> dmem_addr 0x1000, wdata_o=64'hFFFF_FFFF_FFFF_FF80.
//    Same stimulus with LBU -> 64'h80.
//  - SH addr 0x2006, data 64'hBEEF -> dmem_be=8'hC0, dmem_wdata=64'hBEEF_0000_0000_0000, we=1.
//  - LW addr 0x3002 -> no dmem_req_o, misalign_o=1, wdata_o_valid=0.
//  - gnt withheld 4 cycles -> dmem_req_o held, stall_o=1 throughout.
//    Then gnt, rvalid after 2 cycles -> single valid pulse.
//  - Load with no rvalid -> bus_err_o at 255 cycles. Separately, reset pulled mid-WAIT
//    -> req and all outputs 0 asynchronously, state IDLE.

Source files
------------

// File: rtl/mem_access_block_pkg.sv
// Shared RV64I opcode/funct3 constants, memory-stage FSM encoding and an
// alignment helper for the memory-access block.
package mem_access_block_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LD  = 3'b011;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;
  localparam logic [2:0] FUNCT3_LWU = 3'b110;
  localparam logic [2:0] FUNCT3_SB  = 3'b000;
  localparam logic [2:0] FUNCT3_SH  = 3'b001;
  localparam logic [2:0] FUNCT3_SW  = 3'b010;
  localparam logic [2:0] FUNCT3_SD  = 3'b011;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'b00,
    MEM_REQ  = 2'b01,
    MEM_WAIT = 2'b10
  } mem_state_e;

  // size: 0=byte 1=half 2=word 3=double (funct3[1:0])
  function automatic logic misaligned(input logic [1:0] size, input logic [2:0] lane);
    case (size)
      2'b00:   return 1'b0;
      2'b01:   return lane[0];
      2'b10:   return |lane[1:0];
      default: return |lane;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_block_align.sv
// Combinational lane logic: store byte enables/data shift, load extract and
// sign/zero extension, and the misalignment check.
module mem_access_block_align
  import mem_access_block_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [2:0]  lane_i,
  input  logic [63:0] st_data_i,
  input  logic [63:0] ld_data_i,
  output logic [7:0]  be_o,
  output logic [63:0] wdata_o,
  output logic [63:0] ld_result_o,
  output logic        misalign_o
);

  logic [7:0]  be_base_s;
  logic [5:0]  bit_sh_s;
  logic [63:0] ld_shift_s;

  always_comb begin
    bit_sh_s = {lane_i, 3'b000};
    case (funct3_i[1:0])
      2'b00:   be_base_s = 8'h01;
      2'b01:   be_base_s = 8'h03;
      2'b10:   be_base_s = 8'h0F;
      default: be_base_s = 8'hFF;
    endcase
    be_o       = be_base_s << lane_i;
    wdata_o    = st_data_i << bit_sh_s;
    ld_shift_s = ld_data_i >> bit_sh_s;
    case (funct3_i)
      FUNCT3_LB:  ld_result_o = {{56{ld_shift_s[7]}}, ld_shift_s[7:0]};
      FUNCT3_LH:  ld_result_o = {{48{ld_shift_s[15]}}, ld_shift_s[15:0]};
      FUNCT3_LW:  ld_result_o = {{32{ld_shift_s[31]}}, ld_shift_s[31:0]};
      FUNCT3_LBU: ld_result_o = {56'd0, ld_shift_s[7:0]};
      FUNCT3_LHU: ld_result_o = {48'd0, ld_shift_s[15:0]};
      FUNCT3_LWU: ld_result_o = {32'd0, ld_shift_s[31:0]};
      default:    ld_result_o = ld_shift_s;
    endcase
    misalign_o = misaligned(funct3_i[1:0], lane_i);
  end

endmodule

// File: rtl/mem_access_block.sv
// RV64I memory stage: issues aligned loads/stores over req/gnt/rvalid, extends
// load data, passes ALU results through, and stalls execute while busy.
module mem_access_block
  import mem_access_block_pkg::*;
#(
  parameter int TimeoutCycles = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] pc_i,
  input  logic        pc_valid_i,
  input  logic [31:0] inst_i,
  input  logic        inst_valid_i,
  input  logic [63:0] rdata_i,
  input  logic        rdata_valid_i,
  input  logic [63:0] raddr_i,
  input  logic        raddr_valid_i,
  output logic        stall_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [63:0] dmem_addr_o,
  output logic [7:0]  dmem_be_o,
  output logic [63:0] dmem_wdata_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [63:0] dmem_rdata_i,
  output logic [63:0] pc_o,
  output logic        pc_valid_o,
  output logic [31:0] inst_o,
  output logic        inst_valid_o,
  output logic [63:0] wdata_o,
  output logic        wdata_valid_o,
  output logic        misalign_o,
  output logic        bus_err_o
);

  mem_state_e  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [63:0] txn_pc_q, txn_pc_d, txn_addr_q, txn_addr_d, txn_wdata_q, txn_wdata_d;
  logic [31:0] txn_inst_q, txn_inst_d;
  logic        txn_we_q, txn_we_d;
  logic [7:0]  txn_be_q, txn_be_d;
  logic [63:0] pc_q, pc_d, wdata_q, wdata_d;
  logic [31:0] inst_q, inst_d;
  logic        pc_valid_q, pc_valid_d, wdata_valid_q, wdata_valid_d;
  logic        misalign_q, misalign_d, bus_err_q, bus_err_d;

  logic [6:0]  op_s;
  logic [2:0]  f3_s;
  logic        idle_s, accept_s, is_load_s, is_store_s, is_mem_s, start_s;
  logic        store_done_s, load_done_s, timeout_s;
  logic [7:0]  al_be_s;
  logic [63:0] al_wdata_s, al_ld_s;
  logic        al_mis_s;

  assign op_s       = inst_i[6:0];
  assign f3_s       = inst_i[14:12];
  assign idle_s     = (state_q == MEM_IDLE);
  assign accept_s   = idle_s & pc_valid_i & inst_valid_i & rdata_valid_i & raddr_valid_i;
  assign is_load_s  = (op_s == OP_LOAD) && (f3_s != 3'b111);
  assign is_store_s = (op_s == OP_STORE) && !f3_s[2];
  assign is_mem_s   = is_load_s | is_store_s;
  assign start_s    = accept_s & is_mem_s & ~al_mis_s;

  assign store_done_s = (state_q == MEM_REQ) & dmem_gnt_i & txn_we_q;
  assign load_done_s  = (state_q == MEM_WAIT) & dmem_rvalid_i;
  // A completing response in the final cycle takes priority over the timeout.
  assign timeout_s    = !idle_s && (cnt_q == 8'(TimeoutCycles - 1)) && !store_done_s && !load_done_s;

  mem_access_block_align u_align (
    .funct3_i    (idle_s ? f3_s : txn_inst_q[14:12]),
    .lane_i      (idle_s ? raddr_i[2:0] : txn_addr_q[2:0]),
    .st_data_i   (rdata_i),
    .ld_data_i   (dmem_rdata_i),
    .be_o        (al_be_s),
    .wdata_o     (al_wdata_s),
    .ld_result_o (al_ld_s),
    .misalign_o  (al_mis_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MEM_IDLE;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      MEM_IDLE: state_d = start_s ? MEM_REQ : MEM_IDLE;
      MEM_REQ: begin
        if (timeout_s)       state_d = MEM_IDLE;
        else if (dmem_gnt_i) state_d = txn_we_q ? MEM_IDLE : MEM_WAIT;
        else                 state_d = MEM_REQ;
      end
      MEM_WAIT: state_d = (load_done_s || timeout_s) ? MEM_IDLE : MEM_WAIT;
      default:  state_d = MEM_IDLE;
    endcase
    cnt_d = (!idle_s && state_d != MEM_IDLE) ? cnt_q + 8'd1 : 8'd0;
  end

  always_comb begin
    stall_o      = !idle_s;
    dmem_req_o   = (state_q == MEM_REQ);
    dmem_we_o    = txn_we_q;
    dmem_addr_o  = {txn_addr_q[63:3], 3'b000};
    dmem_be_o    = txn_be_q;
    dmem_wdata_o = txn_wdata_q;
    pc_o          = pc_q;
    pc_valid_o    = pc_valid_q;
    inst_o        = inst_q;
    inst_valid_o  = pc_valid_q;
    wdata_o       = wdata_q;
    wdata_valid_o = wdata_valid_q;
    misalign_o    = misalign_q;
    bus_err_o     = bus_err_q;
  end

  always_comb begin
    txn_pc_d      = txn_pc_q;
    txn_inst_d    = txn_inst_q;
    txn_addr_d    = txn_addr_q;
    txn_we_d      = txn_we_q;
    txn_be_d      = txn_be_q;
    txn_wdata_d   = txn_wdata_q;
    pc_d          = pc_q;
    inst_d        = inst_q;
    wdata_d       = wdata_q;
    pc_valid_d    = 1'b0;
    wdata_valid_d = 1'b0;
    misalign_d    = 1'b0;
    bus_err_d     = 1'b0;
    if (start_s) begin
      txn_pc_d    = pc_i;
      txn_inst_d  = inst_i;
      txn_addr_d  = raddr_i;
      txn_we_d    = is_store_s;
      txn_be_d    = is_store_s ? al_be_s : 8'hFF;
      txn_wdata_d = is_store_s ? al_wdata_s : 64'd0;
    end else if (accept_s) begin
      pc_d       = pc_i;
      inst_d     = inst_i;
      pc_valid_d = 1'b1;
      if (is_mem_s) begin
        misalign_d = 1'b1;
      end else begin
        wdata_d       = rdata_i;
        wdata_valid_d = (op_s != OP_BRANCH) && (op_s != OP_STORE);
      end
    end else if (load_done_s) begin
      pc_d          = txn_pc_q;
      inst_d        = txn_inst_q;
      wdata_d       = al_ld_s;
      pc_valid_d    = 1'b1;
      wdata_valid_d = 1'b1;
    end else if (store_done_s || timeout_s) begin
      pc_d       = txn_pc_q;
      inst_d     = txn_inst_q;
      pc_valid_d = 1'b1;
      bus_err_d  = timeout_s;
    end else begin
      pc_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txn_pc_q      <= 64'd0;
      txn_inst_q    <= 32'd0;
      txn_addr_q    <= 64'd0;
      txn_we_q      <= 1'b0;
      txn_be_q      <= 8'd0;
      txn_wdata_q   <= 64'd0;
      pc_q          <= 64'd0;
      inst_q        <= 32'd0;
      wdata_q       <= 64'd0;
      pc_valid_q    <= 1'b0;
      wdata_valid_q <= 1'b0;
      misalign_q    <= 1'b0;
      bus_err_q     <= 1'b0;
    end else begin
      txn_pc_q      <= txn_pc_d;
      txn_inst_q    <= txn_inst_d;
      txn_addr_q    <= txn_addr_d;
      txn_we_q      <= txn_we_d;
      txn_be_q      <= txn_be_d;
      txn_wdata_q   <= txn_wdata_d;
      pc_q          <= pc_d;
      inst_q        <= inst_d;
      wdata_q       <= wdata_d;
      pc_valid_q    <= pc_valid_d;
      wdata_valid_q <= wdata_valid_d;
      misalign_q    <= misalign_d;
      bus_err_q     <= bus_err_d;
    end
  end

endmodule

// File: tb/tb_mem_access_block.sv
// Directed and randomized checks of mem_access_block against a byte-level
// reference model of RV64I load/store behaviour.
module tb_mem_access_block;

  localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011, OP_ALU = 7'b0110011;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic [63:0] pc_i = 64'd0, rdata_i = 64'd0, raddr_i = 64'd0, dmem_rdata_i = 64'd0;
  logic [31:0] inst_i = 32'd0;
  logic        pc_valid_i = 1'b0, inst_valid_i = 1'b0, rdata_valid_i = 1'b0, raddr_valid_i = 1'b0;
  logic        dmem_gnt_i = 1'b0, dmem_rvalid_i = 1'b0;
  logic        stall_o, dmem_req_o, dmem_we_o, pc_valid_o, inst_valid_o, wdata_valid_o;
  logic        misalign_o, bus_err_o;
  logic [63:0] dmem_addr_o, dmem_wdata_o, pc_o, wdata_o;
  logic [7:0]  dmem_be_o;
  logic [31:0] inst_o;

  int total = 0;
  int bad = 0;

  mem_access_block #(.TimeoutCycles(255)) dut (
    .clk(clk), .rst_n(rst_n),
    .pc_i(pc_i), .pc_valid_i(pc_valid_i), .inst_i(inst_i), .inst_valid_i(inst_valid_i),
    .rdata_i(rdata_i), .rdata_valid_i(rdata_valid_i), .raddr_i(raddr_i), .raddr_valid_i(raddr_valid_i),
    .stall_o(stall_o), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o), .dmem_gnt_i(dmem_gnt_i),
    .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
    .pc_o(pc_o), .pc_valid_o(pc_valid_o), .inst_o(inst_o), .inst_valid_o(inst_valid_o),
    .wdata_o(wdata_o), .wdata_valid_o(wdata_valid_o), .misalign_o(misalign_o), .bus_err_o(bus_err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic [63:0] ref_load(input logic [2:0] f3, input logic [63:0] addr, input logic [63:0] m);
    logic [63:0] w = m >> (8 * addr[2:0]);
    int n = nbytes(f3);
    logic [63:0] mask = (n == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * n)) - 64'd1);
    if (f3[2] || n == 8) return w & mask;
    return w[8*n-1] ? (w | ~mask) : (w & mask);
  endfunction

  function automatic logic [7:0] ref_be(input logic [2:0] f3, input logic [63:0] addr);
    logic [7:0] be = 8'd0;
    for (int i = 0; i < 8; i++)
      be[i] = (i >= int'(addr[2:0])) && (i < int'(addr[2:0]) + nbytes(f3));
    return be;
  endfunction

  function automatic logic [63:0] ref_wdata(input logic [63:0] addr, input logic [63:0] d);
    logic [63:0] o = 64'd0;
    int lane = int'(addr[2:0]);
    for (int i = 0; i < 8; i++)
      if (i >= lane) o[8*i +: 8] = d[8*(i-lane) +: 8];
    return o;
  endfunction

  function automatic logic [31:0] mk_inst(input logic [6:0] op, input logic [2:0] f3);
    return {17'd0, f3, 5'd1, op};
  endfunction

  task automatic present(input logic [63:0] pc, input logic [31:0] inst, input logic [63:0] addr, input logic [63:0] data);
    @(negedge clk);
    chk("idle.stall", 64'(stall_o), 64'd0);
    pc_i = pc; inst_i = inst; raddr_i = addr; rdata_i = data;
    pc_valid_i = 1'b1; inst_valid_i = 1'b1; rdata_valid_i = 1'b1; raddr_valid_i = 1'b1;
    @(negedge clk);
    pc_valid_i = 1'b0; inst_valid_i = 1'b0; rdata_valid_i = 1'b0; raddr_valid_i = 1'b0;
  endtask

  task automatic do_op(input string tag, input logic [31:0] inst, input logic [63:0] addr,
                       input logic [63:0] data, input logic [63:0] mem, input int gdly, input int rdly);
    logic [6:0]  op = inst[6:0];
    logic [2:0]  f3 = inst[14:12];
    logic        ld = (op == OP_LOAD) && (f3 != 3'b111);
    logic        st = (op == OP_STORE) && (f3 < 3'd4);
    logic        mis = (ld || st) && ((addr % 64'(nbytes(f3))) != 64'd0);
    logic [63:0] pc = {$urandom, $urandom};
    present(pc, inst, addr, data);
    if (!(ld || st) || mis) begin
      chk({tag, ".req"}, 64'(dmem_req_o), 64'd0);
      chk({tag, ".stall"}, 64'(stall_o), 64'd0);
      chk({tag, ".misalign"}, 64'(misalign_o), 64'(mis));
      chk({tag, ".wvalid"}, 64'(wdata_valid_o), 64'(!mis && op != OP_BRANCH && op != OP_STORE));
      if (!mis && op != OP_BRANCH && op != OP_STORE) chk({tag, ".wdata"}, wdata_o, data);
    end else begin
      for (int k = 0; k < gdly; k++) begin
        chk({tag, ".req_held"}, 64'(dmem_req_o), 64'd1);
        chk({tag, ".stall_req"}, 64'(stall_o), 64'd1);
        chk({tag, ".early_out"}, 64'(pc_valid_o), 64'd0);
        dmem_rvalid_i = 1'b1;
        @(negedge clk);
        dmem_rvalid_i = 1'b0;
      end
      chk({tag, ".req"}, 64'(dmem_req_o), 64'd1);
      chk({tag, ".addr"}, dmem_addr_o, addr & ~64'h7);
      chk({tag, ".we"}, 64'(dmem_we_o), 64'(st));
      if (st) begin
        chk({tag, ".be"}, 64'(dmem_be_o), 64'(ref_be(f3, addr)));
        chk({tag, ".dwdata"}, dmem_wdata_o, ref_wdata(addr, data));
      end
      dmem_gnt_i = 1'b1;
      @(negedge clk);
      dmem_gnt_i = 1'b0;
      if (ld) begin
        for (int k = 0; k < rdly; k++) begin
          chk({tag, ".wait_req"}, 64'(dmem_req_o), 64'd0);
          chk({tag, ".stall_wait"}, 64'(stall_o), 64'd1);
          @(negedge clk);
        end
        dmem_rvalid_i = 1'b1; dmem_rdata_i = mem;
        @(negedge clk);
        dmem_rvalid_i = 1'b0; dmem_rdata_i = {$urandom, $urandom};
      end
      chk({tag, ".misalign"}, 64'(misalign_o), 64'd0);
      chk({tag, ".wvalid"}, 64'(wdata_valid_o), 64'(ld));
      if (ld) chk({tag, ".wdata"}, wdata_o, ref_load(f3, addr, mem));
      chk({tag, ".stall_end"}, 64'(stall_o), 64'd0);
    end
    chk({tag, ".pvalid"}, 64'(pc_valid_o), 64'd1);
    chk({tag, ".ivalid"}, 64'(inst_valid_o), 64'd1);
    chk({tag, ".pc"}, pc_o, pc);
    chk({tag, ".inst"}, 64'(inst_o), 64'(inst));
    chk({tag, ".buserr"}, 64'(bus_err_o), 64'd0);
    @(negedge clk);
    chk({tag, ".pulse"}, 64'({pc_valid_o, wdata_valid_o, misalign_o}), 64'd0);
  endtask

  task automatic do_timeout(input string tag, input logic gnt_first, input logic rv_last);
    logic [63:0] mem = {$urandom, $urandom};
    logic [63:0] addr = 64'h4000;
    present(64'h77, mk_inst(OP_LOAD, 3'b011), addr, 64'd0);
    for (int k = 0; k < 255; k++) begin
      chk({tag, ".stall"}, 64'(stall_o), 64'd1);
      chk({tag, ".req"}, 64'(dmem_req_o), 64'(!gnt_first || k == 0));
      if (k == 0 && gnt_first) dmem_gnt_i = 1'b1;
      if (k == 254 && rv_last) begin dmem_rvalid_i = 1'b1; dmem_rdata_i = mem; end
      @(negedge clk);
      dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
    end
    chk({tag, ".pvalid"}, 64'(pc_valid_o), 64'd1);
    chk({tag, ".req_drop"}, 64'(dmem_req_o), 64'd0);
    chk({tag, ".buserr"}, 64'(bus_err_o), 64'(!rv_last));
    chk({tag, ".wvalid"}, 64'(wdata_valid_o), 64'(rv_last));
    if (rv_last) chk({tag, ".wdata"}, wdata_o, mem);
    @(negedge clk);
    chk({tag, ".pulse"}, 64'({pc_valid_o, bus_err_o}), 64'd0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".ctl"}, 64'({stall_o, dmem_req_o, dmem_we_o, pc_valid_o, inst_valid_o,
                            wdata_valid_o, misalign_o, bus_err_o}), 64'd0);
    chk({tag, ".addr"}, dmem_addr_o, 64'd0);
    chk({tag, ".be_wd"}, dmem_wdata_o | 64'(dmem_be_o), 64'd0);
    chk({tag, ".outs"}, pc_o | wdata_o | 64'(inst_o), 64'd0);
  endtask

  initial begin
    #23;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    do_op("add", mk_inst(OP_ALU, 3'b000), 64'h99, 64'h1234, 64'd0, 0, 0);
    do_op("lb", mk_inst(OP_LOAD, 3'b000), 64'h1003, 64'd0, 64'h0000_0000_8000_0000, 0, 0);
    do_op("lbu", mk_inst(OP_LOAD, 3'b100), 64'h1003, 64'd0, 64'h0000_0000_8000_0000, 0, 0);
    do_op("sh", mk_inst(OP_STORE, 3'b001), 64'h2006, 64'hBEEF, 64'd0, 0, 0);
    do_op("lw_mis", mk_inst(OP_LOAD, 3'b010), 64'h3002, 64'd0, 64'd0, 0, 0);
    do_op("gnt4", mk_inst(OP_LOAD, 3'b011), 64'h5008, 64'd0, 64'hDEAD_BEEF_0BAD_F00D, 4, 2);
    do_op("branch", mk_inst(OP_BRANCH, 3'b001), 64'h10, 64'h55, 64'd0, 0, 0);

    do_timeout("to_req", 1'b0, 1'b0);
    do_timeout("to_wait", 1'b1, 1'b0);
    do_timeout("to_rvwin", 1'b1, 1'b1);

    present(64'h88, mk_inst(OP_LOAD, 3'b011), 64'h6000, 64'd0);
    dmem_gnt_i = 1'b1;
    @(negedge clk);
    dmem_gnt_i = 1'b0;
    chk("rst_mid.inwait", 64'(stall_o), 64'd1);
    #2 rst_n = 1'b0;
    #1 chk_zero("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    do_op("post_rst", mk_inst(OP_LOAD, 3'b101), 64'h7002, 64'd0, 64'h0000_0000_F00D_0000, 1, 1);

    for (int n = 0; n < 40; n++) begin
      int kind = $urandom_range(0, 4);
      logic [2:0] f3 = 3'($urandom_range(0, 7));
      logic [6:0] op;
      logic [63:0] addr = {$urandom, $urandom};
      case (kind)
        0:       op = OP_ALU;
        1:       op = OP_BRANCH;
        3:       op = OP_STORE;
        default: op = OP_LOAD;
      endcase
      if (kind == 3) f3 = {($urandom_range(0, 5) == 0), f3[1:0]};
      if ($urandom_range(0, 2) != 0) addr = addr & ~(64'(nbytes(f3)) - 64'd1);
      do_op("rand", mk_inst(op, f3), addr, {$urandom, $urandom}, {$urandom, $urandom},
            $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
